// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock-enable divider with glitch-free start/stop.
// Emits a one-cycle tick every div_cur cycles and a registered 50%-duty clk_out.
// New ratios arrive over a valid/ready handshake and only take effect on a
// period boundary, so clk_out never produces a short high or low phase.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_out,
  output logic [CNT_W-1:0] div_cur,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] DEFAULT_DIV_W = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE_W         = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             cfg_err_q, cfg_err_d;

  logic             busy_w;
  logic             tick_w;
  logic             accept_w;
  logic [CNT_W-1:0] div_last_w;
  logic [CNT_W-1:0] cfg_val_w;

  // Decode of registered state only; no input reaches an output combinationally.
  always_comb begin
    busy_w     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    div_last_w = div_cur_q - ONE_W;
    tick_w     = busy_w && (cnt_q == div_last_w);
    accept_w   = cfg_valid && !pend_valid_q;
    cfg_val_w  = (cfg_div == '0) ? ONE_W : cfg_div;
  end

  // Next-state logic: counting, clk_out toggling, run/drain control and ratio updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    div_cur_d    = div_cur_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    cfg_err_d    = accept_w && (cfg_div == '0);

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (accept_w) begin
          div_cur_d = cfg_val_w;
        end
        if (en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (tick_w) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end

        // A tick coinciding with en falling is still a RUN tick; DRAIN stops
        // only on a tick that returns clk_out from high to low.
        if (state_q == ST_RUN) begin
          if (!en) begin
            state_d = ST_DRAIN;
          end
        end else if (en) begin
          state_d = ST_RUN;
        end else if (tick_w && clk_out_q) begin
          state_d = ST_IDLE;
        end

        // Ratio changes land only on a tick edge so periods are never cut short.
        if (tick_w) begin
          if (accept_w) begin
            div_cur_d = cfg_val_w;
          end else if (pend_valid_q) begin
            div_cur_d    = pend_div_q;
            pend_valid_d = 1'b0;
          end
        end else if (accept_w) begin
          pend_valid_d = 1'b1;
          pend_div_d   = cfg_val_w;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      div_cur_q    <= DEFAULT_DIV_W;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      div_cur_q    <= div_cur_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready = !pend_valid_q;
  assign cfg_err   = cfg_err_q;
  assign tick      = tick_w;
  assign clk_out   = clk_out_q;
  assign div_cur   = div_cur_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed testbench for clk_div_ctrl. Inputs change and outputs are sampled on
// the falling edge; "cycle k" is the k-th rising-edge interval after reset drops.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic             clk_out;
  logic [CNT_W-1:0] div_cur;
  logic             busy;

  int checks;
  int failures;

  logic [31:0] tick_v;
  logic [31:0] clk_v;
  logic [31:0] busy_v;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .clk_out   (clk_out),
    .div_cur   (div_cur),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset pulse; on return the DUT is in its reset state and it is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    @(negedge clk);
    reset = 1'b0;
    tick_v = '0;
    clk_v  = '0;
    busy_v = '0;
  endtask

  task automatic test_reset();
    do_reset();
    if (tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_tick: got %0b expected 0", tick); end
    checks++;
    if (clk_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_clk_out: got %0b expected 0", clk_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
    checks++;
    if (cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_cfg_err: got %0b expected 0", cfg_err); end
    checks++;
    if (div_cur !== 8'd2) begin failures++; $display("[TB] FAIL reset_div_cur: got %0d expected 2", div_cur); end
    checks++;
  endtask

  // Default N=2: tick on even cycles after en, clk_out period 4.
  task automatic test_default_div();
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
      clk_v[i]  = clk_out;
      busy_v[i] = busy;
    end
    if (tick_v[12:1] !== 12'b101010101010) begin failures++; $display("[TB] FAIL default_tick: got %b expected %b", tick_v[12:1], 12'b101010101010); end
    checks++;
    if (clk_v[12:1] !== 12'b110011001100) begin failures++; $display("[TB] FAIL default_clk_out: got %b expected %b", clk_v[12:1], 12'b110011001100); end
    checks++;
    if (busy_v[12:1] !== 12'hFFF) begin failures++; $display("[TB] FAIL default_busy: got %b expected %b", busy_v[12:1], 12'hFFF); end
    checks++;
    if (div_cur !== 8'd2) begin failures++; $display("[TB] FAIL default_div_cur: got %0d expected 2", div_cur); end
    checks++;
  endtask

  // Ratio written while idle takes effect immediately; N=5 run follows.
  task automatic test_idle_cfg();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_cfg_ready: got %0b expected 1", cfg_ready); end
    checks++;
    if (div_cur !== 8'd5) begin failures++; $display("[TB] FAIL idle_div_cur: got %0d expected 5", div_cur); end
    checks++;
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
      clk_v[i]  = clk_out;
    end
    if (tick_v[20:1] !== 20'b10000100001000010000) begin failures++; $display("[TB] FAIL idle_n5_tick: got %b expected %b", tick_v[20:1], 20'b10000100001000010000); end
    checks++;
    if (clk_v[20:1] !== 20'b11111000001111100000) begin failures++; $display("[TB] FAIL idle_n5_clk_out: got %b expected %b", clk_v[20:1], 20'b11111000001111100000); end
    checks++;
  endtask

  // N=3 running; N=6 offered at cnt=1 is held until the tick, then applied.
  task automatic test_run_cfg();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    en        = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL run_cfg_ready_before: got %0b expected 1", cfg_ready); end
    checks++;
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    if (cfg_ready !== 1'b0) begin failures++; $display("[TB] FAIL run_cfg_ready_pending: got %0b expected 0", cfg_ready); end
    checks++;
    if (tick !== 1'b1) begin failures++; $display("[TB] FAIL run_cfg_tick: got %0b expected 1", tick); end
    checks++;
    if (div_cur !== 8'd3) begin failures++; $display("[TB] FAIL run_cfg_div_old: got %0d expected 3", div_cur); end
    checks++;
    @(negedge clk);
    if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL run_cfg_ready_after: got %0b expected 1", cfg_ready); end
    checks++;
    if (div_cur !== 8'd6) begin failures++; $display("[TB] FAIL run_cfg_div_new: got %0d expected 6", div_cur); end
    checks++;
    for (int i = 5; i <= 10; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
      clk_v[i]  = clk_out;
    end
    if (tick_v[10:5] !== 6'b010000) begin failures++; $display("[TB] FAIL run_cfg_n6_tick: got %b expected %b", tick_v[10:5], 6'b010000); end
    checks++;
    if (clk_v[10:5] !== 6'b011111) begin failures++; $display("[TB] FAIL run_cfg_n6_clk_out: got %b expected %b", clk_v[10:5], 6'b011111); end
    checks++;
  endtask

  // N=4, en dropped while clk_out low: one full high phase, then stop.
  task automatic test_drain();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    en        = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    en        = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
      clk_v[i]  = clk_out;
      busy_v[i] = busy;
    end
    if (tick_v[10:2] !== 9'b001000100) begin failures++; $display("[TB] FAIL drain_tick: got %b expected %b", tick_v[10:2], 9'b001000100); end
    checks++;
    if (clk_v[10:2] !== 9'b001111000) begin failures++; $display("[TB] FAIL drain_clk_out: got %b expected %b", clk_v[10:2], 9'b001111000); end
    checks++;
    if (busy_v[10:2] !== 9'b001111111) begin failures++; $display("[TB] FAIL drain_busy: got %b expected %b", busy_v[10:2], 9'b001111111); end
    checks++;
  endtask

  // Same, but en comes back during DRAIN: the 8-cycle period carries on.
  task automatic test_drain_reraise();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    en        = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    en        = 1'b0;
    for (int i = 2; i <= 17; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
      clk_v[i]  = clk_out;
      busy_v[i] = busy;
      if (i == 3) en = 1'b1;
    end
    if (tick_v[17:2] !== 16'b0100010001000100) begin failures++; $display("[TB] FAIL reraise_tick: got %b expected %b", tick_v[17:2], 16'b0100010001000100); end
    checks++;
    if (clk_v[17:2] !== 16'b0111100001111000) begin failures++; $display("[TB] FAIL reraise_clk_out: got %b expected %b", clk_v[17:2], 16'b0111100001111000); end
    checks++;
    if (busy_v[17:2] !== 16'hFFFF) begin failures++; $display("[TB] FAIL reraise_busy: got %b expected %b", busy_v[17:2], 16'hFFFF); end
    checks++;
  endtask

  // N=2, en falls on a tick with clk_out high: RUN toggle, then a full drain.
  task automatic test_en_fall_on_tick();
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
      clk_v[i]  = clk_out;
      busy_v[i] = busy;
      if (i == 4) en = 1'b0;
    end
    if (busy_v[10:5] !== 6'b001111) begin failures++; $display("[TB] FAIL enfall_busy: got %b expected %b", busy_v[10:5], 6'b001111); end
    checks++;
    if (clk_v[10:5] !== 6'b001100) begin failures++; $display("[TB] FAIL enfall_clk_out: got %b expected %b", clk_v[10:5], 6'b001100); end
    checks++;
  endtask

  // Zero ratio is coerced to 1 with a one-cycle error pulse; output is clk/2.
  task automatic test_cfg_zero();
    do_reset();
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    if (cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL zero_err_before: got %0b expected 0", cfg_err); end
    checks++;
    @(negedge clk);
    cfg_valid = 1'b0;
    if (cfg_err !== 1'b1) begin failures++; $display("[TB] FAIL zero_err_pulse: got %0b expected 1", cfg_err); end
    checks++;
    if (div_cur !== 8'd1) begin failures++; $display("[TB] FAIL zero_div_cur: got %0d expected 1", div_cur); end
    checks++;
    en = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
      clk_v[i]  = clk_out;
      if (i == 2) begin
        if (cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL zero_err_after: got %0b expected 0", cfg_err); end
        checks++;
      end
    end
    if (tick_v[9:2] !== 8'hFF) begin failures++; $display("[TB] FAIL zero_tick: got %b expected %b", tick_v[9:2], 8'hFF); end
    checks++;
    if (clk_v[9:2] !== 8'b10101010) begin failures++; $display("[TB] FAIL zero_clk_out: got %b expected %b", clk_v[9:2], 8'b10101010); end
    checks++;
  endtask

  // Reset while running with a pending ratio discards it and restores defaults.
  task automatic test_reset_pending();
    do_reset();
    en = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    @(negedge clk);
    cfg_valid = 1'b0;
    if (cfg_ready !== 1'b0) begin failures++; $display("[TB] FAIL rstp_pending: got %0b expected 0", cfg_ready); end
    checks++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if ({clk_out, tick, busy, cfg_ready, cfg_err} !== 5'b00010) begin
      failures++;
      $display("[TB] FAIL rstp_outputs: got %b expected %b", {clk_out, tick, busy, cfg_ready, cfg_err}, 5'b00010);
    end
    checks++;
    if (div_cur !== 8'd2) begin failures++; $display("[TB] FAIL rstp_div_cur: got %0d expected 2", div_cur); end
    checks++;
    for (int i = 4; i <= 7; i++) begin
      @(negedge clk);
      tick_v[i] = tick;
    end
    if (tick_v[7:4] !== 4'b1010) begin failures++; $display("[TB] FAIL rstp_tick: got %b expected %b", tick_v[7:4], 4'b1010); end
    checks++;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    $display("[TB] starting clk_div_ctrl tests");
    test_reset();
    test_default_div();
    test_idle_cfg();
    test_run_cfg();
    test_drain();
    test_drain_reraise();
    test_en_fall_on_tick();
    test_cfg_zero();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable clock-enable divider controller for the clock-divider family.
- Produces a one-cycle `tick` enable every N input cycles and a registered 50%-duty `clk_out` (period 2N) in the single `clk` domain. No derived clocks are used.
- The divide ratio is reconfigured through a valid/ready handshake and applied only at period boundaries, so `clk_out` never glitches.
- Start/stop via `en` is also glitch-free: `clk_out` always parks low.

Parameters:
- CNT_W, 8, width of divide ratio and internal counter.
- DEFAULT_DIV, 2, ratio loaded at reset (must be 1..2^CNT_W-1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  run request; high = run divider, low = drain and stop
- cfg_valid  in  1  new ratio offered
- cfg_div  in  CNT_W  requested ratio N
- cfg_ready  out  1  controller can accept a ratio
- cfg_err  out  1  one-cycle pulse: accepted cfg_div was 0, coerced to 1
- tick  out  1  one-cycle enable, once per N cycles
- clk_out  out  1  registered divided output, toggles after each tick
- div_cur  out  CNT_W  ratio currently in effect
- busy  out  1  state is RUN or DRAIN

Behaviour:
- Reset, sampled on a `clk` rising edge. All effects are visible the next cycle:
  - state=IDLE, cnt=0, clk_out=0, tick=0, cfg_err=0.
  - cfg_ready=1, div_cur=DEFAULT_DIV, pending cleared.
  - Reset overrides all other inputs, including mid-period and with a pending config.
- States:
  - IDLE: cnt held at 0, clk_out=0, tick=0.
    - en=1 sampled → RUN next cycle, with cnt=0.
  - RUN: cnt counts 0..div_cur-1.
    - tick=1 during the cycle where cnt==div_cur-1.
    - At the edge ending that cycle: cnt←0 and clk_out←~clk_out.
    - en=0 sampled → DRAIN (counting continues unchanged).
  - DRAIN: counting identical to RUN.
    - At a tick edge where clk_out is 1, clk_out←0 and state→IDLE. This is the first such tick.
    - en=1 sampled in DRAIN → RUN with no counter disturbance.
- First tick comes N cycles after entering RUN.
  - Example N=4, en sampled at cycle 0: RUN from cycle 1, tick in cycle 4, clk_out=1 cycles 5-8, tick cycle 8, clk_out=0 from cycle 9.
- Config handshake: accept = cfg_valid & cfg_ready.
  - IDLE: div_cur←cfg_div at the accept edge; cfg_ready stays 1.
  - RUN/DRAIN: value is stored as pending and cfg_ready=0 from the next cycle.
    - Pending is applied at the next tick edge: div_cur←pending, cnt←0.
    - cfg_ready returns to 1 the cycle after application.
  - Accept in a tick cycle: applied at that same edge. The next period uses the new N.
  - Reaching IDLE through DRAIN with a pending value: applied on the final tick edge.
  - cfg_div=0: stored as 1; cfg_err=1 for exactly the cycle after accept.
- N=1: tick is high every cycle in RUN; clk_out toggles every cycle (clk/2).
- div_cur and the current cnt never change mid-period except via reset.
- Counter compare uses full CNT_W width; no wrap beyond div_cur-1.
- Simultaneous en fall and tick in RUN:
  - The tick is processed as a RUN tick, including the clk_out toggle.
  - DRAIN starts next cycle and still requires a tick with clk_out=1 to stop.
- Outputs tick, clk_out, cfg_ready, cfg_err, busy are driven from flops or decode of registered state only. There is no combinational path from inputs.

Test Plan:
- Reset, then en=1 with default N=2 → tick every 2nd cycle starting cycle 2 after en; clk_out period 4; div_cur=2.
- In IDLE, cfg_div=5 with valid → cfg_ready stays 1, div_cur=5 next cycle. Then en=1 → first tick 5 cycles after RUN entry; clk_out high 5, low 5.
- RUN with N=3, cfg_div=6 accepted mid-period (cnt=1) → cfg_ready=0 until the tick. The next period is 6 cycles and cnt restarts at 0; cfg_ready=1 the cycle after.
- RUN with N=4: drop en while clk_out=0 → clk_out goes 1 at next tick, then 0 at the following tick; busy falls with it and no short pulses occur. Repeat with en re-raised in DRAIN → continuous 8-cycle clk_out period.
- cfg_div=0 accepted → cfg_err single pulse, div_cur=1, tick every cycle, clk_out toggles each cycle.
- Assert reset during RUN with a pending config → next cycle clk_out=0, tick=0, busy=0, cfg_ready=1, div_cur=DEFAULT_DIV, pending discarded.
